// File: rtl/cache_arbiter.sv
// -----------------------------------------------------------------------------
// cache_arbiter
//
// Purpose:
//   Shares the single cacheline port of the cacheline adapter between the
//   instruction cache (read only) and the data cache (read/write). One client
//   is granted at a time. The granted address, direction and writeback line
//   are captured in registers. They are held toward the adapter until the
//   adapter's one-cycle mem_resp. That response, and the fill line on reads,
//   is returned to the granted client only.
//
// Ports:
//   clk, reset_n          clock (rising edge), asynchronous active-low reset
//   icache_read           I-cache fill request (level)
//   icache_address        I-cache line address
//   icache_line           fill data to I-cache, zero unless icache_resp
//   icache_resp           one-cycle completion to I-cache
//   dcache_read           D-cache fill request (level)
//   dcache_write          D-cache writeback request (level)
//   dcache_address        D-cache line address
//   dcache_line_i         D-cache writeback line
//   dcache_line_o         fill data to D-cache, zero unless dcache_resp
//   dcache_resp           one-cycle completion to D-cache
//   mem_read, mem_write   registered request toward the adapter
//   mem_address           registered address toward the adapter
//   mem_line_o            registered writeback line toward the adapter
//   mem_line_i            fill line from the adapter
//   mem_resp              one-cycle completion from the adapter
// -----------------------------------------------------------------------------
module cache_arbiter #(
   parameter int LINE_W     = 256,
   parameter int ADDR_W     = 32,
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              icache_read,
   input  logic [ADDR_W-1:0] icache_address,
   output logic [LINE_W-1:0] icache_line,
   output logic              icache_resp,
   input  logic              dcache_read,
   input  logic              dcache_write,
   input  logic [ADDR_W-1:0] dcache_address,
   input  logic [LINE_W-1:0] dcache_line_i,
   output logic [LINE_W-1:0] dcache_line_o,
   output logic              dcache_resp,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_address,
   output logic [LINE_W-1:0] mem_line_o,
   input  logic [LINE_W-1:0] mem_line_i,
   input  logic              mem_resp
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2
   } state_t;

   localparam logic GRANT_I = 1'b0;
   localparam logic GRANT_D = 1'b1;

   state_t            state;
   state_t            state_next;
   logic              last_grant;
   logic [ADDR_W-1:0] req_addr;
   logic [LINE_W-1:0] req_line;
   logic              req_we;
   logic              req_rd;

   logic              i_req;
   logic              d_req;
   logic              pick_d;
   logic              d_is_write;
   logic              start;
   logic              done;

   assign mem_address = req_addr;
   assign mem_line_o  = req_line;
   assign mem_read    = req_rd;
   assign mem_write   = req_we;

   // Request decode and arbitration among the two clients while idle.
   always_comb begin
      i_req      = icache_read;
      d_req      = dcache_read | dcache_write;
      // read and write together is illegal; it is treated as a write
      d_is_write = dcache_write;
      pick_d     = 1'b0;
      if (d_req && !i_req) begin
         pick_d = 1'b1;
      end else if (d_req && i_req) begin
         // tie: fixed priority favours D, otherwise the client not served last
         if (FIXED_PRIO) begin
            pick_d = 1'b1;
         end else begin
            pick_d = (last_grant == GRANT_I);
         end
      end else begin
         pick_d = 1'b0;
      end
   end

   // Next-state logic plus the combinational completion outputs.
   always_comb begin
      state_next    = state;
      start         = 1'b0;
      done          = 1'b0;
      icache_resp   = 1'b0;
      dcache_resp   = 1'b0;
      icache_line   = {LINE_W{1'b0}};
      dcache_line_o = {LINE_W{1'b0}};
      case (state)
         IDLE: begin
            // mem_resp here is spurious and deliberately ignored
            if (i_req || d_req) begin
               start      = 1'b1;
               state_next = pick_d ? SERVE_D : SERVE_I;
            end else begin
               state_next = IDLE;
            end
         end
         SERVE_I: begin
            if (mem_resp) begin
               done        = 1'b1;
               icache_resp = 1'b1;
               icache_line = mem_line_i;
               state_next  = IDLE;
            end else begin
               state_next = SERVE_I;
            end
         end
         SERVE_D: begin
            if (mem_resp) begin
               done        = 1'b1;
               dcache_resp = 1'b1;
               // a writeback completion returns no data
               if (req_we) begin
                  dcache_line_o = {LINE_W{1'b0}};
               end else begin
                  dcache_line_o = mem_line_i;
               end
               state_next = IDLE;
            end else begin
               state_next = SERVE_D;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Transaction registers: captured on grant, cleared on completion so the
   // adapter sees a quiet IDLE cycle between transactions.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         req_addr   <= {ADDR_W{1'b0}};
         req_line   <= {LINE_W{1'b0}};
         req_we     <= 1'b0;
         req_rd     <= 1'b0;
         last_grant <= GRANT_I;
      end else if (start) begin
         req_addr <= pick_d ? dcache_address : icache_address;
         req_we   <= pick_d & d_is_write;
         req_rd   <= ~(pick_d & d_is_write);
         req_line <= (pick_d && d_is_write) ? dcache_line_i : {LINE_W{1'b0}};
      end else if (done) begin
         req_addr   <= {ADDR_W{1'b0}};
         req_line   <= {LINE_W{1'b0}};
         req_we     <= 1'b0;
         req_rd     <= 1'b0;
         last_grant <= (state == SERVE_D) ? GRANT_D : GRANT_I;
      end else begin
         req_addr   <= req_addr;
         req_line   <= req_line;
         req_we     <= req_we;
         req_rd     <= req_rd;
         last_grant <= last_grant;
      end
   end

endmodule
